axis_downsizer: RTL and testbench

//   AXI-Stream width down-converter: splits each wide DMA beat into RATIO narrow sub-words, LSB sub-word first.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_downsizer.sv | 101 ++++++++++
 tb/tb_axis_downsizer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream width down-converter.
package axis_pkg;

  localparam int KEEP_MAX = 64;

  typedef enum logic {EMPTY, DRAIN} dsz_state_t;

  // Highest set bit of a keep vector.
  function automatic logic [5:0] msb_index(input logic [KEEP_MAX-1:0] keep);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) begin
        r = 6'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// AXI-Stream width down-converter: splits each wide beat into RATIO narrow sub-words,
// LSB first, truncating at the highest kept sub-word and placing tlast on the final one.
module axis_downsizer
  import axis_pkg::*;
#(
  parameter int S_AXIS_WIDTH = 64,
  parameter int M_AXIS_WIDTH = 16,
  localparam int RATIO = S_AXIS_WIDTH / M_AXIS_WIDTH,
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic [S_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic [RATIO-1:0]        s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [M_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    err_drop_last
);

  dsz_state_t              state_q, state_d;
  logic [S_AXIS_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                    buf_last_q, buf_last_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_idx_q, last_idx_d;
  logic                    err_q, err_d;

  logic at_last_s;
  logic out_hs_s;
  logic in_hs_s;

  // Handshake decode, output mux and next-state for the holding register.
  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    err_d      = err_q;

    at_last_s     = (idx_q == last_idx_q);
    m_axis_tvalid = (state_q == DRAIN);
    out_hs_s      = m_axis_tvalid & m_axis_tready;
    // Accept the next beat in the same cycle the final sub-word leaves: no bubble between beats.
    s_axis_tready = (state_q == EMPTY) | (out_hs_s & at_last_s);
    in_hs_s       = s_axis_tvalid & s_axis_tready;
    m_axis_tdata  = buf_data_q[idx_q*M_AXIS_WIDTH +: M_AXIS_WIDTH];
    m_axis_tlast  = buf_last_q & at_last_s;

    if (in_hs_s && (s_axis_tkeep != {RATIO{1'b0}})) begin
      state_d    = DRAIN;
      buf_data_d = s_axis_tdata;
      buf_last_d = s_axis_tlast;
      idx_d      = {IDX_W{1'b0}};
      last_idx_d = IDX_W'(msb_index(KEEP_MAX'(s_axis_tkeep)));
    end else if (in_hs_s) begin
      // Empty beat carries no data; a tlast on it means the packet end is lost.
      state_d = EMPTY;
      err_d   = err_q | s_axis_tlast;
    end else if (out_hs_s && at_last_s) begin
      state_d = EMPTY;
    end else if (out_hs_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      state_d = state_q;
    end
  end

  // State and holding register.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= EMPTY;
      buf_data_q <= {S_AXIS_WIDTH{1'b0}};
      buf_last_q <= 1'b0;
      idx_q      <= {IDX_W{1'b0}};
      last_idx_q <= {IDX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Sticky dropped-tlast flag, cleared only by reset.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_drop_last = err_q;

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer with a queue-based reference split checked every cycle.
module tb_axis_downsizer;

  localparam int SW = 64;
  localparam int MW = 16;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] s_axis_tdata;
  logic [R-1:0]  s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [MW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          err_drop_last;

  axis_downsizer #(.S_AXIS_WIDTH(SW), .M_AXIS_WIDTH(MW)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .err_drop_last (err_drop_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [MW-1:0] data;
  } sub_t;

  sub_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted beat yields sub-words 0..highest-kept, tlast on the final one.
  logic [MW-1:0] prev_data;
  logic          prev_last;
  bit            prev_stall = 1'b0;
  bit            exp_err = 1'b0;

  always @(negedge clk) begin : monitor
    int   n;
    sub_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      exp_err    = 1'b0;
    end else begin
      check("tvalid_vs_model", m_axis_tvalid, exp_q.size() != 0);
      check("err_flag", err_drop_last, exp_err);
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h with nothing expected", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_last", m_axis_tlast, e.last);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) begin
        n = 0;
        for (int i = 0; i < R; i++) if (s_axis_tkeep[i]) n = i + 1;
        for (int i = 0; i < n; i++) exp_q.push_back({s_axis_tlast && (i == n - 1), s_axis_tdata[i*MW +: MW]});
        if (n == 0 && s_axis_tlast) exp_err = 1'b1;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [SW-1:0] d, input logic [R-1:0] k, input logic l, input bit hold);
    bit ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
    @(posedge clk);
    #1;
    if (!hold) s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!m_axis_tvalid && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d sub-words still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [MW-1:0] t1_words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [SW-1:0] b2 [3] = '{64'h0D0C_0B0A_0908_0706, 64'h1D1C_1B1A_1918_1716, 64'h2D2C_2B2A_2928_2726};

  initial begin : main
    int out_cnt;
    int rdy_cnt;
    int bi;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 16'h0000);
    check("rst_err", err_drop_last, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 1'b1);

    // Single full beat: four sub-words on consecutive cycles, tlast with the last.
    @(posedge clk);
    #1;
    send(64'h4444_3333_2222_1111, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", m_axis_tvalid, 1'b1);
      check("t1_data", m_axis_tdata, t1_words[i]);
      check("t1_last", m_axis_tlast, i == 3);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("t1_idle", m_axis_tvalid, 1'b0);
    @(posedge clk);
    #1;

    // Three back-to-back full beats: 12 sub-words without gaps, input ready 3 of 12 cycles.
    out_cnt = 0;
    rdy_cnt = 0;
    bi = 0;
    s_axis_tdata  = b2[0];
    s_axis_tkeep  = 4'hF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) out_cnt++;
      if (k > 0 && s_axis_tready) rdy_cnt++;
      if (s_axis_tvalid && s_axis_tready) bi++;
      @(posedge clk);
      #1;
      if (bi < 3) begin
        s_axis_tdata = b2[bi];
        s_axis_tlast = (bi == 2);
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
    check("t2_out_count", out_cnt, 12);
    check("t2_ready_count", rdy_cnt, 3);
    wait_idle();

    // Partial final beat followed immediately by a new beat.
    send(64'h0123_4567_89AB_CDEF, 4'hF, 1'b0, 1'b1);
    send(64'h5555_6666_BBBB_AAAA, 4'h3, 1'b1, 1'b1);
    s_axis_tdata = 64'hDDDD_CCCC_9999_8888;
    s_axis_tkeep = 4'hF;
    s_axis_tlast = 1'b1;
    @(negedge clk);
    check("t3_data0", m_axis_tdata, 16'hAAAA);
    check("t3_last0", m_axis_tlast, 1'b0);
    check("t3_ready0", s_axis_tready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_data1", m_axis_tdata, 16'hBBBB);
    check("t3_last1", m_axis_tlast, 1'b1);
    check("t3_ready1", s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("t3_next_valid", m_axis_tvalid, 1'b1);
    check("t3_next_data", m_axis_tdata, 16'h8888);
    wait_idle();

    // 100-beat packet with random output backpressure.
    rand_en = 1'b1;
    for (int b = 0; b < 100; b++) begin
      send({$urandom, $urandom}, 4'hF, b == 99, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    wait_idle();
    rand_en = 1'b0;
    @(posedge clk);
    #1;

    // Empty tlast beat: dropped, sticky error until reset.
    send(64'hDEAD_BEEF_0000_0000, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_err_set", err_drop_last, 1'b1);
    check("t5_no_out", m_axis_tvalid, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send(64'h0000_0000_0000_7777, 4'h1, 1'b1, 1'b0);
    wait_idle();
    check("t5_err_sticky", err_drop_last, 1'b1);

    // Reset in the middle of a beat, after two of four sub-words.
    send(64'hA004_A003_A002_A001, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_sub0", m_axis_tdata, 16'hA001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_sub1", m_axis_tdata, 16'hA002);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_axis_tvalid, 1'b0);
    check("t6_rst_data", m_axis_tdata, 16'h0000);
    check("t6_rst_err", err_drop_last, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(64'hB004_B003_B002_B001, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_restart_valid", m_axis_tvalid, 1'b1);
    check("t6_restart_data", m_axis_tdata, 16'hB001);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
